// File: rtl/usrt_tx_sched_if.sv
// Producer/serializer-facing signal bundle of the USRT transmit scheduler.
// slave is the scheduler's view; master is the view of whatever drives it.
interface usrt_tx_sched_if;
  logic             en;
  logic [1:0]       req;
  logic [6:0]       len0;
  logic [6:0]       len1;
  logic [7:0]       src_data0;
  logic [7:0]       src_data1;
  logic [1:0]       src_valid;
  logic [1:0]       src_ready;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             rts;
  logic             busy;

  modport master (
    output en, req, len0, len1, src_data0, src_data1, src_valid, tx_ready,
    input  src_ready, grant, done, tx_data, tx_valid, rts, busy
  );

  modport slave (
    input  en, req, len0, len1, src_data0, src_data1, src_valid, tx_ready,
    output src_ready, grant, done, tx_data, tx_valid, rts, busy
  );
endinterface

// File: rtl/usrt_tx_sched.sv
// Two-source round-robin scheduler framing messages (SOF, info, payload,
// two's-complement checksum) onto one USRT byte serializer, with RTS guard time.
module usrt_tx_sched #(
  parameter logic [7:0]  SOF      = 8'h7E,
  parameter int unsigned LEAD_CYC = 4,
  parameter int unsigned TAIL_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  usrt_tx_sched_if.slave    bus
);

  localparam logic [7:0] LEAD_LAST = 8'(LEAD_CYC - 1);
  localparam logic [7:0] TAIL_LAST = 8'(TAIL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SOF, S_INFO, S_PAY, S_CKS, S_TAIL
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       tmr_q, tmr_d;

  logic [1:0][7:0]  src_data;
  logic [1:0][6:0]  len;
  logic             gid, pick, go, xfer, tmr_end;
  logic [7:0]       info;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic [1:0]       src_ready;
  logic [1:0]       done;

  assign src_data = {bus.src_data1, bus.src_data0};
  assign len      = {bus.len1, bus.len0};
  assign gid      = grant_q[1];
  // cnt_q still holds the latched length while INFO is on the wire
  assign info     = {gid, cnt_q};
  assign go       = bus.en && (bus.req != 2'b00);
  assign xfer     = tx_valid && bus.tx_ready;
  assign tmr_end  = (state_q == S_LEAD) ? (tmr_q == LEAD_LAST) : (tmr_q == TAIL_LAST);

  // ptr_q is the last-granted source; on a tie the other one wins
  always_comb begin
    case (bus.req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~ptr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= 7'd0;
      sum_q   <= 8'd0;
      tmr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          grant_d = pick ? 2'b10 : 2'b01;
          ptr_d   = pick;
          cnt_d   = len[pick];
          sum_d   = 8'd0;
          tmr_d   = 8'd0;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (tmr_end) begin
          tmr_d   = 8'd0;
          state_d = S_SOF;
        end else begin
          tmr_d   = tmr_q + 8'd1;
        end
      end
      S_SOF: begin
        if (xfer) state_d = S_INFO;
      end
      S_INFO: begin
        if (xfer) begin
          sum_d   = sum_q + info;
          state_d = (cnt_q != 7'd0) ? S_PAY : S_CKS;
        end
      end
      S_PAY: begin
        // leaving on cnt_q==1 keeps the counter from ever wrapping
        if (xfer) begin
          sum_d = sum_q + tx_data;
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = S_CKS;
        end
      end
      S_CKS: begin
        if (xfer) begin
          tmr_d   = 8'd0;
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (tmr_end) begin
          grant_d = 2'b00;
          state_d = S_IDLE;
        end else begin
          tmr_d   = tmr_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    src_ready = 2'b00;
    done      = 2'b00;
    case (state_q)
      S_SOF: begin
        tx_valid = 1'b1;
        tx_data  = SOF;
      end
      S_INFO: begin
        tx_valid = 1'b1;
        tx_data  = info;
      end
      S_PAY: begin
        tx_valid  = bus.src_valid[gid];
        tx_data   = src_data[gid];
        src_ready = grant_q & {2{bus.tx_ready}};
      end
      S_CKS: begin
        tx_valid = 1'b1;
        tx_data  = ~sum_q + 8'd1;
      end
      S_TAIL: begin
        if (tmr_end) done = grant_q;
      end
      default: ;
    endcase
  end

  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;
  assign bus.src_ready = src_ready;
  assign bus.done      = done;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rts       = (state_q != S_IDLE);

  a_grant_1hot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_pay_cnt:    assert property (@(posedge clk) disable iff (rst) (state_q == S_PAY) |-> (cnt_q != 7'd0));

endmodule

// File: tb/tb_usrt_tx_sched.sv
// Directed bench for usrt_tx_sched: byte stream capture, RTS/grant/done tracking
// and hand-computed frame contents.
module tb_usrt_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usrt_tx_sched_if bus();

  usrt_tx_sched #(.SOF(8'h7E), .LEAD_CYC(4), .TAIL_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // source models, captured stream and per-test counters
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] got[$];
  logic [7:0] stall_q[$];
  logic [7:0] ex[$];
  bit         adv0, adv1, prev_stall;
  logic [7:0] prev_d;
  logic [1:0] exp_grant, done_val;
  int rts_cyc, pre_cnt, done_cyc, grant_bad, srdy1_cyc, hold_bad;

  // inputs change on negedge, sampling at negedge+1 sees what the next posedge sees
  always @(negedge clk) begin
    if (adv0 && q0.size() > 0) q0.delete(0);
    if (adv1 && q1.size() > 0) q1.delete(0);
    bus.src_valid = {q1.size() > 0, q0.size() > 0};
    bus.src_data0 = (q0.size() > 0) ? q0[0] : 8'h00;
    bus.src_data1 = (q1.size() > 0) ? q1[0] : 8'h00;
    #1;
    adv0 = !rst && bus.src_valid[0] && bus.src_ready[0];
    adv1 = !rst && bus.src_valid[1] && bus.src_ready[1];
    if (!rst) begin
      if (bus.rts) begin
        rts_cyc++;
        if (bus.grant !== exp_grant) grant_bad++;
        if (got.size() == 0 && !bus.tx_valid) pre_cnt++;
      end
      if (bus.done != 2'b00) begin
        done_cyc++;
        done_val = done_val | bus.done;
      end
      if (bus.src_ready[1]) srdy1_cyc++;
      if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_d)) hold_bad++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_d     = bus.tx_data;
      if (prev_stall) stall_q.push_back(bus.tx_data);
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clr();
    got.delete();
    stall_q.delete();
    rts_cyc = 0; pre_cnt = 0; done_cyc = 0; grant_bad = 0; srdy1_cyc = 0; hold_bad = 0;
    done_val = 2'b00;
  endtask

  task automatic wait_busy(input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk); #2;
      if (bus.busy) seen = 1;
    end
    chk("busy_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk); #2;
      if (bus.done != 2'b00) seen = 1;
    end
    chk("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_got(input int n, input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk); #2;
      if (got.size() >= n) seen = 1;
    end
    chk("got_timeout", 32'(seen), 32'd1);
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_n"}, 32'(got.size()), 32'(ex.size()));
    for (int i = 0; i < ex.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(ex[i]));
  endtask

  initial begin
    bus.en = 1'b0; bus.req = 2'b00; bus.len0 = 7'd0; bus.len1 = 7'd0; bus.tx_ready = 1'b1;
    exp_grant = 2'b00;
    clr();
    repeat (3) @(negedge clk);
    #2 chk("rst_outs", 32'({bus.rts, bus.busy, bus.tx_valid, bus.grant, bus.done, bus.src_ready}), 32'd0);
    @(negedge clk) rst = 1'b0;

    // basic len=3 frame from source 0
    @(negedge clk);
    clr(); q0 = {8'h10, 8'h20, 8'h30};
    bus.len0 = 7'd3; bus.en = 1'b1; bus.req = 2'b01; exp_grant = 2'b01;
    wait_busy(10);
    @(negedge clk) bus.req = 2'b00;
    wait_done(100);
    ex = {8'h7E, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
    chk_bytes("t1");
    chk("t1_lead", 32'(pre_cnt), 32'd4);
    chk("t1_rts_cyc", 32'(rts_cyc), 32'd12);
    chk("t1_grant", 32'(grant_bad), 32'd0);
    chk("t1_done_n", 32'(done_cyc), 32'd1);
    chk("t1_done_v", 32'(done_val), 32'd1);
    @(negedge clk); #2 chk("t1_rts_fall", 32'(bus.rts), 32'd0);

    // req=11 held: round-robin 1,0,1 with one idle cycle between frames
    @(negedge clk);
    clr(); q1 = {8'hA1, 8'hA2}; q0 = {8'h05};
    bus.len0 = 7'd1; bus.len1 = 7'd1; bus.req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      exp_grant = (k == 1) ? 2'b01 : 2'b10;
      wait_busy(10);
      if (k == 2) begin
        @(negedge clk) bus.req = 2'b00;
      end
      wait_done(100);
      @(negedge clk); #2 chk($sformatf("t2_gap%0d", k), 32'(bus.rts), 32'd0);
    end
    ex = {8'h7E, 8'h81, 8'hA1, 8'hDE, 8'h7E, 8'h01, 8'h05, 8'hFA, 8'h7E, 8'h81, 8'hA2, 8'hDD};
    chk_bytes("t2");
    chk("t2_grant", 32'(grant_bad), 32'd0);
    chk("t2_done_n", 32'(done_cyc), 32'd3);

    // 5-cycle serializer stall during INFO of a len=2 frame
    @(negedge clk);
    clr(); q0 = {8'h11, 8'h22};
    bus.len0 = 7'd2; bus.req = 2'b01; exp_grant = 2'b01;
    wait_busy(10);
    @(negedge clk) bus.req = 2'b00;
    wait_got(1, 50);
    @(negedge clk) bus.tx_ready = 1'b0;
    repeat (5) @(negedge clk);
    bus.tx_ready = 1'b1;
    wait_done(100);
    ex = {8'h7E, 8'h02, 8'h11, 8'h22, 8'hCB};
    chk_bytes("t4");
    chk("t4_stall_n", 32'(stall_q.size()), 32'd5);
    chk("t4_stall_d", (stall_q.size() > 0) ? 32'(stall_q[stall_q.size()-1]) : 32'hDEAD, 32'h02);
    chk("t4_hold", 32'(hold_bad), 32'd0);

    // zero-length frame from source 1
    @(negedge clk);
    clr(); bus.len1 = 7'd0; bus.req = 2'b10; exp_grant = 2'b10;
    wait_busy(10);
    @(negedge clk) bus.req = 2'b00;
    wait_done(100);
    ex = {8'h7E, 8'h80, 8'h80};
    chk_bytes("t3");
    chk("t3_srdy1", 32'(srdy1_cyc), 32'd0);
    chk("t3_grant", 32'(grant_bad), 32'd0);

    // reset mid-payload, then a fresh frame with the pointer back at 0
    @(negedge clk);
    clr(); q0 = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    bus.len0 = 7'd5; bus.len1 = 7'd1; bus.req = 2'b11; exp_grant = 2'b01;
    wait_busy(10);
    chk("t5_grant0", 32'(bus.grant), 32'h1);
    wait_got(4, 60);
    @(negedge clk) rst = 1'b1;
    #2 chk("t5_rst_outs", 32'({bus.rts, bus.busy, bus.tx_valid, bus.grant, bus.done, bus.src_ready}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q0.delete(); clr(); q1 = {8'h3C}; exp_grant = 2'b10;
    wait_busy(10);
    chk("t5_ptr_rst", 32'(bus.grant), 32'h2);
    @(negedge clk) bus.req = 2'b00;
    wait_done(100);
    ex = {8'h7E, 8'h81, 8'h3C, 8'h43};
    chk_bytes("t5");
    chk("t5_grant", 32'(grant_bad), 32'd0);

    // en gating: no grant while low, grant right after it rises, frame survives its fall
    @(negedge clk);
    clr(); bus.en = 1'b0; q0 = {8'h99}; bus.len0 = 7'd1; bus.req = 2'b01; exp_grant = 2'b01;
    repeat (20) @(negedge clk);
    #2;
    chk("t6_en0_rts", 32'(rts_cyc), 32'd0);
    chk("t6_en0_grant", 32'(bus.grant), 32'd0);
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk); #2 chk("t6_grant_next", 32'(bus.grant), 32'h1);
    @(negedge clk) bus.en = 1'b0;
    wait_done(100);
    ex = {8'h7E, 8'h01, 8'h99, 8'h66};
    chk_bytes("t6");
    @(negedge clk) clr();
    repeat (15) @(negedge clk);
    #2 chk("t6_no_regrant", 32'(rts_cyc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/usrt_tx_sched.md
Name: usrt_tx_sched

Overview:
- Arbitrates two message sources, e.g. the start/button message path and the measurement data path, onto the single USRT byte serializer.
- Wraps each granted message in a frame: SOF, info byte, payload, checksum.
- Drives RTS around each frame with lead and tail guard intervals.
- Sits between the message producers and the USRT transmitter. The serializer owns bit timing on usrt_clk; this block runs entirely on clk.

Parameters:
- SOF, 8'h7E, start-of-frame byte.
- LEAD_CYC, 4, clk cycles RTS is high before SOF is offered (range 1..255).
- TAIL_CYC, 2, clk cycles RTS stays high after the checksum is accepted (range 1..255).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  transmit enable (sw6); gates new grants only.
- req  in  2  per-source request; level, sampled in IDLE.
- len0  in  7  source 0 payload length in bytes (0..127).
- len1  in  7  source 1 payload length in bytes (0..127).
- src_data0  in  8  source 0 payload byte.
- src_data1  in  8  source 1 payload byte.
- src_valid  in  2  per-source payload byte valid.
- src_ready  out  2  per-source payload byte accepted.
- grant  out  2  one-hot; the granted source, held for the whole frame.
- done  out  2  one-cycle pulse to the granted source at frame end.
- tx_data  out  8  byte to the serializer.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  serializer accepts the byte.
- rts  out  1  request-to-send line.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0, so source 1 has priority first; checksum accumulator 0.
- Transfer rule: a byte transfers on a cycle where tx_valid and tx_ready are both high. While tx_valid=1 and tx_ready=0, tx_data must hold stable.
- IDLE: if en=1 and req!=0, grant per the table below. Register grant, latch the granted len into cnt, clear the checksum, then go to LEAD.
  - req=01: grant source 0.
  - req=10: grant source 1.
  - req=11: grant the source other than the last-granted one; update the pointer on grant.
- LEAD: rts=1; count LEAD_CYC cycles, then go to SOF.
- SOF: tx_valid=1, tx_data=SOF. On transfer go to INFO. SOF is excluded from the checksum.
- INFO: tx_valid=1, tx_data={grant_id, len_latched}, where grant_id is 0 or 1. On transfer add the byte to the checksum, then go to PAY if len>0, else go to CKS.
- PAY: combinational pass-through.
  - tx_data=src_data[g], tx_valid=src_valid[g], src_ready[g]=tx_ready. The non-granted src_ready stays 0.
  - On each transfer: add the byte to the checksum and decrement cnt.
  - On the transfer where cnt==1, go to CKS.
- CKS: tx_valid=1, tx_data=(~sum+1) mod 256, registered. The 8-bit sum of info + payload + checksum is therefore 0. On transfer go to TAIL.
- TAIL: rts=1; count TAIL_CYC cycles. On the final cycle pulse done[g]=1 for one cycle, clear grant, go to IDLE.
- rts is 1 from the first LEAD cycle through the last TAIL cycle inclusive; otherwise 0.
- Checksum arithmetic is 8-bit wrap-around.
- Boundary conditions:
  - len=0: frame is SOF, INFO, CKS; the checksum equals -info.
  - len=127: the 7-bit counter must not underflow.
  - req is ignored outside IDLE. Dropping req mid-frame does not abort the frame; the block never aborts a frame.
  - en falling mid-frame: the current frame completes. en=0 blocks only the next grant.
  - A new req arriving in the done cycle is considered in the following IDLE cycle. Minimum gap between frames is 1 IDLE cycle with rts=0.
  - tx_ready may toggle arbitrarily; stalls of any length are legal.
  - src_valid=0 in PAY gives tx_valid=0 with no counter or checksum change.
  - Async reset mid-frame: all outputs go to 0 immediately; the serializer must tolerate a tx_valid drop.

Test Plan:
- req=01, len0=3, payload 0x10,0x20,0x30, tx_ready=1 → after 4 rts cycles the bytes 7E,03,10,20,30,9D are sent; grant=01 throughout; done[0] pulses after 2 tail cycles; rts then falls.
- req=11 held for three frames, both len=1 → grants are source 1, then source 0, then source 1; info bytes 81,01,81.
- len1=0 with req=10 → bytes 7E,80,80; src_ready[1] never asserts.
- tx_ready low for 5 cycles during INFO of a len=2 frame → tx_data holds 0x02 stable, no counter/checksum change, frame completes with the correct checksum.
- rst pulsed during PAY of a len=5 frame after 2 payload bytes → next cycle rts=0, tx_valid=0, grant=00, busy=0; with req still asserted, a fresh frame starts cleanly with pointer reset.
- en=0 with req=01 → no grant, rts=0 for 20 cycles. Set en=1 → grant on the next cycle. Clear en mid-frame → the frame completes, no new grant follows.
